// File: rtl/psk_pkg.sv
// Shared PSK definitions: mode encoding, per-mode symbol geometry and mapper FSM states.
// The receiver side imports the same mode encoding so both ends agree on the constellation.
package psk_pkg;

    localparam logic MODE_BPSK = 1'b1;
    localparam logic MODE_QPSK = 1'b0;

    localparam int BPS_BPSK  = 1;
    localparam int BPS_QPSK  = 2;
    localparam int NSYM_BPSK = 8;
    localparam int NSYM_QPSK = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } psk_state_e;

endpackage

// File: rtl/psk_const_map.sv
// Combinational constellation lookup: (mode, symbol bits) -> (I, Q) at +/-AMP.
// In BPSK only sym[1] is meaningful and drives both rails.
module psk_const_map
    import psk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMP   = 8192
) (
    input  logic                    mode,
    input  logic [1:0]              sym,
    output logic signed [WIDTH-1:0] i_val,
    output logic signed [WIDTH-1:0] q_val
);

    localparam logic signed [WIDTH-1:0] POS_AMP = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] NEG_AMP = -POS_AMP;

    // Select the constellation point for the current mode
    always_comb begin
        i_val = sym[1] ? POS_AMP : NEG_AMP;
        if (mode == MODE_BPSK) begin
            q_val = i_val;
        end else begin
            q_val = sym[0] ? POS_AMP : NEG_AMP;
        end
    end

endmodule

// File: rtl/psk_symbol_mapper.sv
// Byte stream to BPSK/QPSK I/Q symbols with rectangular SPS-fold upsampling.
// Bytes reload seamlessly at end_of_byte; mode is only sampled when a byte loads.
module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SPS   = 8,
    parameter int AMP   = 8192
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    is_bpsk,
    input  logic [7:0]              s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    output logic signed [WIDTH-1:0] out_I_tdata,
    output logic                    out_I_tvalid,
    output logic signed [WIDTH-1:0] out_Q_tdata,
    output logic                    out_Q_tvalid,
    output logic                    sym_tick,
    output logic                    is_bpsk_used,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int                SAMP_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SPS - 1);

    psk_state_e              state_r, state_nxt_s;
    logic [SAMP_W-1:0]       samp_cnt_r;
    logic [2:0]              sym_cnt_r;
    logic [2:0]              sym_last_s;
    logic [7:0]              shreg_r, shreg_shift_s;
    logic                    mode_r, tlast_r, tick_r, valid_r, frame_done_r;
    logic                    eob_s, load_s, map_mode_s;
    logic [1:0]              map_sym_s;
    logic signed [WIDTH-1:0] i_r, q_r, map_i_s, map_q_s;

    psk_const_map #(.WIDTH(WIDTH), .AMP(AMP)) u_map (
        .mode  (map_mode_s),
        .sym   (map_sym_s),
        .i_val (map_i_s),
        .q_val (map_q_s)
    );

    // Handshake, end-of-byte detection and mapper input selection
    always_comb begin
        sym_last_s    = (mode_r == MODE_QPSK) ? 3'(NSYM_QPSK - 1) : 3'(NSYM_BPSK - 1);
        eob_s         = (state_r == ST_RUN) && (samp_cnt_r == SAMP_LAST) && (sym_cnt_r == sym_last_s);
        s_tready      = (state_r == ST_IDLE) || eob_s;
        load_s        = s_tvalid && s_tready;
        shreg_shift_s = (mode_r == MODE_BPSK) ? (shreg_r << BPS_BPSK) : (shreg_r << BPS_QPSK);
        if (load_s) begin
            map_mode_s = is_bpsk;
            map_sym_s  = s_tdata[7:6];
        end else begin
            map_mode_s = mode_r;
            map_sym_s  = shreg_shift_s[7:6];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (eob_s && !load_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: byte load, symbol stepping and registered I/Q outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt_r   <= '0;
            sym_cnt_r    <= 3'd0;
            shreg_r      <= 8'd0;
            mode_r       <= MODE_BPSK;
            tlast_r      <= 1'b0;
            tick_r       <= 1'b0;
            valid_r      <= 1'b0;
            frame_done_r <= 1'b0;
            i_r          <= '0;
            q_r          <= '0;
        end else begin
            valid_r      <= 1'b1;
            frame_done_r <= eob_s && tlast_r;
            if (load_s) begin
                samp_cnt_r <= '0;
                sym_cnt_r  <= 3'd0;
                shreg_r    <= s_tdata;
                mode_r     <= is_bpsk;
                tlast_r    <= s_tlast;
                tick_r     <= 1'b1;
                i_r        <= map_i_s;
                q_r        <= map_q_s;
            end else if (eob_s) begin
                samp_cnt_r <= '0;
                sym_cnt_r  <= 3'd0;
                tick_r     <= 1'b0;
                i_r        <= '0;
                q_r        <= '0;
            end else if (state_r == ST_RUN && samp_cnt_r == SAMP_LAST) begin
                samp_cnt_r <= '0;
                sym_cnt_r  <= sym_cnt_r + 3'd1;
                shreg_r    <= shreg_shift_s;
                tick_r     <= 1'b1;
                i_r        <= map_i_s;
                q_r        <= map_q_s;
            end else if (state_r == ST_RUN) begin
                samp_cnt_r <= samp_cnt_r + SAMP_W'(1);
                tick_r     <= 1'b0;
            end else begin
                tick_r     <= 1'b0;
                i_r        <= '0;
                q_r        <= '0;
            end
        end
    end

    assign out_I_tdata  = i_r;
    assign out_Q_tdata  = q_r;
    assign out_I_tvalid = valid_r;
    assign out_Q_tvalid = valid_r;
    assign sym_tick     = tick_r;
    assign is_bpsk_used = mode_r;
    assign busy         = (state_r == ST_RUN);
    assign frame_done   = frame_done_r;

endmodule
